// File: rtl/chacha_session_ctrl.sv
// ChaCha20 session controller: TRNG key/nonce acquisition, block counter, automatic re-keying.
// Optional core watchdog is compiled in with `define CHACHA_CTRL_WATCHDOG_EN.
module chacha_session_ctrl #(
    parameter int unsigned REKEY_BLOCKS = 1024,
    parameter logic [31:0] COUNTER_INIT = 32'h00000001,
    parameter int unsigned WDOG_CYCLES  = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         rekey,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         key_valid,
    input  logic [31:0]  trng_data,
    input  logic         trng_ready,
    output logic         trng_request,
    output logic         core_start,
    input  logic         core_busy,
    input  logic         core_done,
    output logic [255:0] key,
    output logic [95:0]  nonce,
    output logic [31:0]  counter
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQUIRE,
        S_READY,
        S_START_CHACHA,
        S_WAIT_FOR_CHACHA,
        S_DONE
    } state_t;

    localparam logic [3:0]  LAST_WORD  = 4'd10;
    localparam logic [31:0] LAST_BLOCK = 32'(REKEY_BLOCKS - 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             key_valid_q, key_valid_d;
    logic             trng_request_q, trng_request_d;
    logic             core_start_q, core_start_d;
    logic [7:0][31:0] key_q, key_d;
    logic [2:0][31:0] nonce_q, nonce_d;
    logic [31:0]      counter_q, counter_d;
    logic [3:0]       word_cnt_q, word_cnt_d;
    logic [31:0]      block_cnt_q, block_cnt_d;
    logic             rekey_pend_q, rekey_pend_d;
    logic             enter_acquire;
    logic             unused_inputs;

`ifdef CHACHA_CTRL_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic        error_q, error_d;
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    assign error         = error_q;
    assign unused_inputs = core_busy;
`else
    assign error         = 1'b0;
    assign unused_inputs = ^{core_busy, 32'(WDOG_CYCLES)};
`endif

    always_comb begin
        // NOTE: every *_d starts from a default so no path through the case can infer a latch.
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        core_start_d   = 1'b0;
        key_valid_d    = key_valid_q;
        trng_request_d = trng_request_q;
        key_d          = key_q;
        nonce_d        = nonce_q;
        counter_d      = counter_q;
        word_cnt_d     = word_cnt_q;
        block_cnt_d    = block_cnt_q;
        rekey_pend_d   = rekey_pend_q;
        enter_acquire  = 1'b0;
`ifdef CHACHA_CTRL_WATCHDOG_EN
        error_d        = error_q;
        wdog_cnt_d     = wdog_cnt_q;
`endif
        case (state_q)
            S_IDLE: enter_acquire = 1'b1;
            S_ACQUIRE: begin
                // Words 0..7 fill the key MSB-first, words 8..10 fill the nonce MSB-first.
                if (trng_request_q && trng_ready) begin
                    if (word_cnt_q[3]) nonce_d[2'd2 - word_cnt_q[1:0]] = trng_data;
                    else               key_d[3'd7 - word_cnt_q[2:0]]   = trng_data;
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == LAST_WORD) begin
                        trng_request_d = 1'b0;
                        key_valid_d    = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = S_READY;
                    end
                end
            end
            S_READY: begin
                if (rekey) begin
                    enter_acquire = 1'b1;
                end else if (start) begin
                    state_d      = S_START_CHACHA;
                    busy_d       = 1'b1;
                    core_start_d = 1'b1;
                end
            end
            S_START_CHACHA: begin
                state_d      = S_WAIT_FOR_CHACHA;
                rekey_pend_d = rekey_pend_q | rekey;
`ifdef CHACHA_CTRL_WATCHDOG_EN
                wdog_cnt_d   = '0;
`endif
            end
            S_WAIT_FOR_CHACHA: begin
                rekey_pend_d = rekey_pend_q | rekey;
                if (core_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef CHACHA_CTRL_WATCHDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    error_d       = 1'b1;
                    enter_acquire = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                counter_d   = counter_q + 32'd1;
                block_cnt_d = block_cnt_q + 32'd1;
                if (block_cnt_q == LAST_BLOCK || counter_q == 32'hFFFF_FFFF ||
                    rekey_pend_q || rekey) begin
                    enter_acquire = 1'b1;
                end else begin
                    state_d = S_READY;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entering acquisition discards the old session entirely, including any counter advance.
        if (enter_acquire) begin
            state_d        = S_ACQUIRE;
            busy_d         = 1'b1;
            key_valid_d    = 1'b0;
            trng_request_d = 1'b1;
            key_d          = '0;
            nonce_d        = '0;
            word_cnt_d     = '0;
            block_cnt_d    = '0;
            counter_d      = COUNTER_INIT;
            rekey_pend_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every register has a reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            key_valid_q    <= 1'b0;
            trng_request_q <= 1'b0;
            core_start_q   <= 1'b0;
            key_q          <= '0;
            nonce_q        <= '0;
            counter_q      <= COUNTER_INIT;
            word_cnt_q     <= '0;
            block_cnt_q    <= '0;
            rekey_pend_q   <= 1'b0;
`ifdef CHACHA_CTRL_WATCHDOG_EN
            error_q        <= 1'b0;
            wdog_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            key_valid_q    <= key_valid_d;
            trng_request_q <= trng_request_d;
            core_start_q   <= core_start_d;
            key_q          <= key_d;
            nonce_q        <= nonce_d;
            counter_q      <= counter_d;
            word_cnt_q     <= word_cnt_d;
            block_cnt_q    <= block_cnt_d;
            rekey_pend_q   <= rekey_pend_d;
`ifdef CHACHA_CTRL_WATCHDOG_EN
            error_q        <= error_d;
            wdog_cnt_q     <= wdog_cnt_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign key_valid    = key_valid_q;
    assign trng_request = trng_request_q;
    assign core_start   = core_start_q;
    assign key          = key_q;
    assign nonce        = nonce_q;
    assign counter      = counter_q;

endmodule

// File: tb/tb_chacha_session_ctrl.sv
// Self-checking bench for chacha_session_ctrl: two instances (short re-key budget, wrapping counter)
// checked against a session-level reference model with randomized TRNG data and core latencies.
module tb_chacha_session_ctrl;
    localparam int unsigned RK0 = 2;
    localparam int unsigned RK1 = 1024;
    localparam logic [31:0] CI0 = 32'h0000_0001;
    localparam logic [31:0] CI1 = 32'hFFFF_FFFF;
    localparam int unsigned WD1 = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start [2];
    logic rekey [2];
    logic trng_ready [2];
    logic core_busy [2];
    logic core_done [2];
    logic [31:0] trng_data [2];
    logic busy [2];
    logic done [2];
    logic error [2];
    logic key_valid [2];
    logic trng_request [2];
    logic core_start [2];
    logic [255:0] key [2];
    logic [95:0] nonce [2];
    logic [31:0] counter [2];

    always #5 clk = ~clk;

    chacha_session_ctrl #(.REKEY_BLOCKS(RK0), .COUNTER_INIT(CI0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .rekey(rekey[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .key_valid(key_valid[0]),
        .trng_data(trng_data[0]), .trng_ready(trng_ready[0]), .trng_request(trng_request[0]),
        .core_start(core_start[0]), .core_busy(core_busy[0]), .core_done(core_done[0]),
        .key(key[0]), .nonce(nonce[0]), .counter(counter[0])
    );

    chacha_session_ctrl #(.REKEY_BLOCKS(RK1), .COUNTER_INIT(CI1), .WDOG_CYCLES(WD1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .rekey(rekey[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .key_valid(key_valid[1]),
        .trng_data(trng_data[1]), .trng_ready(trng_ready[1]), .trng_request(trng_request[1]),
        .core_start(core_start[1]), .core_busy(core_busy[1]), .core_done(core_done[1]),
        .key(key[1]), .nonce(nonce[1]), .counter(counter[1])
    );

    // Session-level reference model, one entry per instance.
    int unsigned  rk_blocks [2] = '{RK0, RK1};
    logic [31:0]  cinit [2]     = '{CI0, CI1};
    logic [255:0] m_key [2];
    logic [95:0]  m_nonce [2];
    logic [31:0]  m_ctr [2];
    int unsigned  m_blocks [2];
    logic         m_err [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_rekey(input int u);
        m_key[u]    = '0;
        m_nonce[u]  = '0;
        m_ctr[u]    = cinit[u];
        m_blocks[u] = 0;
    endtask

    task automatic check_reset(input int u);
        check("rst_busy", busy[u], 1'b0);
        check("rst_done", done[u], 1'b0);
        check("rst_error", error[u], 1'b0);
        check("rst_key_valid", key_valid[u], 1'b0);
        check("rst_trng_request", trng_request[u], 1'b0);
        check("rst_core_start", core_start[u], 1'b0);
        check("rst_key", key[u], '0);
        check("rst_nonce", nonce[u], '0);
        check("rst_counter", counter[u], cinit[u]);
    endtask

    // Feeds 11 TRNG words (fixed 1..11 or random), optionally with gaps in trng_ready.
    task automatic acquire(input int u, input bit fixed, input bit gaps);
        logic [31:0] w [11];
        int k = 0;
        int guard = 0;
        bit fire;
        for (int i = 0; i < 11; i++) w[i] = fixed ? 32'(i + 1) : $urandom;
        while (k < 11 && guard < 200) begin
            check("acq_request", trng_request[u], 1'b1);
            check("acq_busy", busy[u], 1'b1);
            trng_ready[u] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            trng_data[u]  = trng_ready[u] ? w[k] : $urandom;
            fire = trng_ready[u];
            step();
            if (fire) k++;
            guard++;
        end
        trng_ready[u] = 1'b0;
        trng_data[u]  = '0;
        check("acq_words", 32'(k), 32'd11);
        for (int i = 0; i < 8; i++) m_key[u] = {m_key[u][223:0], w[i]};
        for (int i = 8; i < 11; i++) m_nonce[u] = {m_nonce[u][63:0], w[i]};
        check("acq_key_valid", key_valid[u], 1'b1);
        check("acq_request_off", trng_request[u], 1'b0);
        check("acq_busy_off", busy[u], 1'b0);
        check("acq_key", key[u], m_key[u]);
        check("acq_nonce", nonce[u], m_nonce[u]);
        check("acq_counter", counter[u], m_ctr[u]);
    endtask

    // One block: core_done arrives lat cycles after core_start (lat >= 2).
    // rk_mode: 0 no rekey, 1 rekey while waiting for the core, 2 rekey during the done cycle.
    task automatic run_block(input int u, input int lat, input int rk_mode, input bit extra_start);
        bit due;
        check("blk_ready", busy[u], 1'b0);
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("blk_core_start", core_start[u], i == 0);
            check("blk_busy", busy[u], 1'b1);
            check("blk_done_early", done[u], 1'b0);
            check("blk_key_stable", key[u], m_key[u]);
            check("blk_nonce_stable", nonce[u], m_nonce[u]);
            check("blk_counter_stable", counter[u], m_ctr[u]);
            start[u] = extra_start && (i == 1);
            rekey[u] = (rk_mode == 1) && (i == lat - 1);
            step();
        end
        start[u] = 1'b0;
        rekey[u] = 1'b0;
        core_done[u] = 1'b1;
        step();
        core_done[u] = 1'b0;
        check("blk_done", done[u], 1'b1);
        check("blk_done_counter", counter[u], m_ctr[u]);
        check("blk_done_key", key[u], m_key[u]);
        check("blk_done_busy", busy[u], 1'b1);
        rekey[u] = (rk_mode == 2);
        due = (m_blocks[u] + 1 == rk_blocks[u]) || (m_ctr[u] == 32'hFFFF_FFFF) || (rk_mode != 0);
        m_ctr[u] = m_ctr[u] + 32'd1;
        m_blocks[u]++;
        step();
        rekey[u] = 1'b0;
        check("blk_done_pulse", done[u], 1'b0);
        check("blk_core_start_once", core_start[u], 1'b0);
        check("blk_error", error[u], m_err[u]);
        if (due) begin
            model_rekey(u);
            check("rk_key_valid", key_valid[u], 1'b0);
            check("rk_trng_request", trng_request[u], 1'b1);
            check("rk_busy", busy[u], 1'b1);
            check("rk_key", key[u], m_key[u]);
            check("rk_nonce", nonce[u], m_nonce[u]);
            check("rk_counter", counter[u], m_ctr[u]);
        end else begin
            check("nxt_busy", busy[u], 1'b0);
            check("nxt_key_valid", key_valid[u], 1'b1);
            check("nxt_counter", counter[u], m_ctr[u]);
            check("nxt_trng_request", trng_request[u], 1'b0);
        end
        step();
        check("blk_no_queued_start", core_start[u], 1'b0);
        check("blk_no_second_done", done[u], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; rekey[u] = 1'b0; trng_ready[u] = 1'b0;
            core_busy[u] = 1'b0; core_done[u] = 1'b0; trng_data[u] = '0;
            m_err[u] = 1'b0;
            model_rekey(u);
        end
        repeat (3) step();
        for (int u = 0; u < 2; u++) check_reset(u);

        rst_n = 1'b1;
        step();
        for (int u = 0; u < 2; u++) begin
            check("entry_trng_request", trng_request[u], 1'b1);
            check("entry_busy", busy[u], 1'b1);
            check("entry_key_valid", key_valid[u], 1'b0);
        end

        // Fixed TRNG words 1..11 with trng_ready held high.
        acquire(0, 1'b1, 1'b0);
        check("tp_key", key[0],
              256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        check("tp_nonce", nonce[0], 96'h00000009_0000000A_0000000B);
        check("tp_counter", counter[0], 32'd1);

        run_block(0, 20, 0, 1'b0);
        run_block(0, 5, 0, 1'b1);
        acquire(0, 1'b0, 1'b1);
        run_block(0, 7, 1, 1'b1);
        acquire(0, 1'b0, 1'b1);

        // core_done outside S_WAIT_FOR_CHACHA is ignored.
        core_done[0] = 1'b1;
        step();
        core_done[0] = 1'b0;
        check("idle_done_ignored", done[0], 1'b0);
        check("idle_done_busy", busy[0], 1'b0);
        step();
        check("idle_done_ignored2", done[0], 1'b0);

        // rekey in S_READY starts a new acquisition immediately.
        rekey[0] = 1'b1;
        step();
        rekey[0] = 1'b0;
        model_rekey(0);
        check("ready_rekey_valid", key_valid[0], 1'b0);
        check("ready_rekey_req", trng_request[0], 1'b1);
        check("ready_rekey_key", key[0], m_key[0]);
        check("ready_rekey_counter", counter[0], m_ctr[0]);
        acquire(0, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            run_block(0, int'($urandom_range(2, 12)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                      1'($urandom_range(0, 1)));
            if (m_blocks[0] == 0) acquire(0, 1'b0, 1'b1);
        end

        // Counter at 32'hFFFFFFFF forces a re-key after one block.
        acquire(1, 1'b0, 1'b1);
        run_block(1, 4, 0, 1'b0);
        acquire(1, 1'b0, 1'b0);
`ifdef CHACHA_CTRL_WATCHDOG_EN
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int i = 0; i <= int'(WD1); i++) begin
            check("wdog_error_early", error[1], 1'b0);
            check("wdog_done_none", done[1], 1'b0);
            step();
        end
        check("wdog_error", error[1], 1'b1);
        check("wdog_done", done[1], 1'b0);
        check("wdog_reacquire", trng_request[1], 1'b1);
        check("wdog_key_valid", key_valid[1], 1'b0);
        m_err[1] = 1'b1;
        model_rekey(1);
        acquire(1, 1'b0, 1'b0);
        check("wdog_sticky", error[1], 1'b1);
`else
        run_block(1, 300, 0, 1'b0);
        acquire(1, 1'b0, 1'b0);
`endif

        // Reset in the middle of a block; the late core result must be ignored.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        for (int u = 0; u < 2; u++) begin
            check_reset(u);
            m_err[u] = 1'b0;
            model_rekey(u);
        end
        rst_n = 1'b1;
        core_done[0] = 1'b1;
        step();
        check("late_done_ignored", done[0], 1'b0);
        check("late_trng_request", trng_request[0], 1'b1);
        step();
        core_done[0] = 1'b0;
        check("late_done_ignored2", done[0], 1'b0);
        acquire(0, 1'b0, 1'b1);
        run_block(0, 3, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
